// File: rtl/mem_interface_if.sv
// Sequencer-to-memory bus: MAR/MDR request side in, Mdatain/busy/done status out.
// fault only exists when MEM_RANGE_CHECK_EN is defined.
interface mem_interface_if #(
   parameter int DATA_W = 32
);
   logic [31:0]       MARaddr;
   logic [DATA_W-1:0] MDRdata;
   logic              Read;
   logic              Write;
   logic [DATA_W-1:0] Mdatain;
   logic              busy;
   logic              done;
`ifdef MEM_RANGE_CHECK_EN
   logic              fault;

   modport master (
      output MARaddr, MDRdata, Read, Write,
      input  Mdatain, busy, done, fault
   );

   modport slave (
      input  MARaddr, MDRdata, Read, Write,
      output Mdatain, busy, done, fault
   );
`else
   modport master (
      output MARaddr, MDRdata, Read, Write,
      input  Mdatain, busy, done
   );

   modport slave (
      input  MARaddr, MDRdata, Read, Write,
      output Mdatain, busy, done
   );
`endif
endinterface

// File: rtl/mem_interface.sv
// Single-outstanding word RAM stage; done WAIT_STATES+1 edges after acceptance.
// No backpressure: requests seen outside IDLE are dropped. MEM_RANGE_CHECK_EN adds fault.
module mem_interface #(
   parameter int ADDR_W      = 9,
   parameter int DATA_W      = 32,
   parameter int WAIT_STATES = 2
) (
   input  logic           clock,
   input  logic           clear,
   mem_interface_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] WS_L = 4'(WAIT_STATES);

   state_t            r_state;
   state_t            w_next_state;

   logic              r_op;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [3:0]        r_cnt;
   logic [DATA_W-1:0] r_mdatain;
   logic              r_oor;

   logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

   logic              w_accept;
   logic              w_access;
   logic              w_busy;
   logic              w_done;
   logic              w_fault;
   logic              w_oor_in;

`ifdef MEM_RANGE_CHECK_EN
   assign w_oor_in = |bus.MARaddr[31:ADDR_W];
`else
   logic  w_unused_upper;
   assign w_unused_upper = &{1'b0, bus.MARaddr[31:ADDR_W]};
   assign w_oor_in       = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (clear) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (bus.Write || bus.Read) w_next_state = S_WAIT;
         S_WAIT:  if (r_cnt == 4'd0)         w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_accept = 1'b0;
      w_access = 1'b0;
      w_busy   = 1'b0;
      w_done   = 1'b0;
      w_fault  = 1'b0;
      case (r_state)
         S_IDLE: w_accept = bus.Write || bus.Read;
         S_WAIT: begin
            w_busy   = 1'b1;
            w_access = (r_cnt == 4'd0);
         end
         S_DONE: begin
            w_done  = 1'b1;
            w_fault = r_oor;
         end
         default: ;
      endcase
   end

   // Write wins over Read when both are asserted; write data is only captured for writes.
   always_ff @(posedge clock) begin
      if (clear) begin
         r_op      <= 1'b0;
         r_addr    <= '0;
         r_data    <= '0;
         r_cnt     <= 4'd0;
         r_mdatain <= '0;
         r_oor     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op   <= bus.Write;
            r_addr <= bus.MARaddr[ADDR_W-1:0];
            r_cnt  <= WS_L;
            r_oor  <= w_oor_in;
            if (bus.Write) begin
               r_data <= bus.MDRdata;
            end
         end else if (w_busy && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_access && !r_op && !r_oor) begin
            r_mdatain <= r_mem[r_addr];
         end
      end
   end

   // RAM is never reset; a clear landing on the access edge suppresses the write.
   always_ff @(posedge clock) begin
      if (w_access && r_op && !r_oor && !clear) begin
         r_mem[r_addr] <= r_data;
      end
   end

   assign bus.Mdatain = r_mdatain;
   assign bus.busy    = w_busy;
   assign bus.done    = w_done;
`ifdef MEM_RANGE_CHECK_EN
   assign bus.fault   = w_fault;
`else
   logic  w_unused_fault;
   assign w_unused_fault = w_fault;
`endif

endmodule

// File: tb/tb_mem_interface.sv
// Randomized bench for mem_interface against a behavioural memory/latency model.
module tb_mem_interface;

   localparam int AW   = 9;
   localparam int DW   = 32;
   localparam int WS_A = 2;
   localparam int WS_B = 0;
   localparam int WS_C = 5;

   logic clock = 1'b0;
   logic clear;
   always #5 clock = ~clock;

   mem_interface_if #(.DATA_W(DW)) bus_a ();
   mem_interface_if #(.DATA_W(DW)) bus_b ();
   mem_interface_if #(.DATA_W(DW)) bus_c ();

   mem_interface #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS_A)) u_dut_a (
      .clock(clock), .clear(clear), .bus(bus_a));
   mem_interface #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS_B)) u_dut_b (
      .clock(clock), .clear(clear), .bus(bus_b));
   mem_interface #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS_C)) u_dut_c (
      .clock(clock), .clear(clear), .bus(bus_c));

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] mem_m  [3][512];
   bit          known  [3][512];
   logic [31:0] mdat_m [3];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int ws_of(input int sel);
      case (sel)
         0:       return WS_A;
         1:       return WS_B;
         default: return WS_C;
      endcase
   endfunction

   task automatic set_req(input int sel, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data);
      case (sel)
         0: begin bus_a.Read = rd; bus_a.Write = wr; bus_a.MARaddr = addr; bus_a.MDRdata = data; end
         1: begin bus_b.Read = rd; bus_b.Write = wr; bus_b.MARaddr = addr; bus_b.MDRdata = data; end
         default: begin bus_c.Read = rd; bus_c.Write = wr; bus_c.MARaddr = addr; bus_c.MDRdata = data; end
      endcase
   endtask

   function automatic logic get_done(input int sel);
      case (sel)
         0:       return bus_a.done;
         1:       return bus_b.done;
         default: return bus_c.done;
      endcase
   endfunction

   function automatic logic get_busy(input int sel);
      case (sel)
         0:       return bus_a.busy;
         1:       return bus_b.busy;
         default: return bus_c.busy;
      endcase
   endfunction

   function automatic logic [31:0] get_mdat(input int sel);
      case (sel)
         0:       return bus_a.Mdatain;
         1:       return bus_b.Mdatain;
         default: return bus_c.Mdatain;
      endcase
   endfunction

`ifdef MEM_RANGE_CHECK_EN
   function automatic logic get_fault(input int sel);
      case (sel)
         0:       return bus_a.fault;
         1:       return bus_b.fault;
         default: return bus_c.fault;
      endcase
   endfunction
`endif

   // One request from an idle DUT; inputs are scrambled after acceptance.
   task automatic xact(input int sel, input logic wr, input logic rd,
                       input logic [31:0] addr, input logic [31:0] data, input bit poke);
      int          ws;
      int          lat;
      int          nbusy;
      logic [31:0] a;
      bit          oor;
      ws  = ws_of(sel);
      a   = {23'd0, addr[AW-1:0]};
`ifdef MEM_RANGE_CHECK_EN
      oor = (addr[31:AW] != 0);
`else
      oor = 1'b0;
`endif
      @(negedge clock);
      set_req(sel, rd, wr, addr, data);
      @(posedge clock); #1;
      set_req(sel, 1'b0, 1'b0, $urandom, $urandom);
      lat   = -1;
      nbusy = 0;
      for (int k = 0; k < 40; k++) begin
         if (get_done(sel)) begin
            lat = k;
            break;
         end
         if (get_busy(sel)) nbusy++;
         if (poke && k == 0) set_req(sel, 1'b1, 1'b0, $urandom, $urandom);
         if (poke && k == 1) set_req(sel, 1'b0, 1'b0, $urandom, $urandom);
         @(posedge clock); #1;
      end
      set_req(sel, 1'b0, 1'b0, $urandom, $urandom);
      if (!oor) begin
         if (wr) begin
            mem_m[sel][a] = data;
            known[sel][a] = 1'b1;
         end else if (rd) begin
            mdat_m[sel] = mem_m[sel][a];
         end
      end
      chk("latency", 64'(lat), 64'(ws + 1));
      chk("busy_cycles", 64'(nbusy), 64'(ws + 1));
      chk("mdatain", 64'(get_mdat(sel)), 64'(mdat_m[sel]));
`ifdef MEM_RANGE_CHECK_EN
      chk("fault_done", 64'(get_fault(sel)), 64'(oor));
`endif
      @(posedge clock); #1;
      chk("done_one_cycle", 64'(get_done(sel)), 64'd0);
      chk("busy_after", 64'(get_busy(sel)), 64'd0);
`ifdef MEM_RANGE_CHECK_EN
      chk("fault_after", 64'(get_fault(sel)), 64'd0);
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int          seen;
      int          low;
      logic [31:0] v5;
      logic [31:0] addr;
      logic        wr;
      logic        rd;

      for (int s = 0; s < 3; s++) begin
         mdat_m[s] = '0;
         set_req(s, 1'b0, 1'b0, '0, '0);
      end
      clear = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_busy", 64'(bus_a.busy), 64'd0);
      chk("rst_done", 64'(bus_a.done), 64'd0);
      chk("rst_mdat", 64'(bus_a.Mdatain), 64'd0);
`ifdef MEM_RANGE_CHECK_EN
      chk("rst_fault", 64'(bus_a.fault), 64'd0);
`endif
      clear = 1'b0;

      // Write then read back, plus the latency sweep on the 0- and 5-wait instances.
      xact(0, 1'b1, 1'b0, 32'h012, 32'hDEADBEEF, 1'b0);
      xact(0, 1'b0, 1'b1, 32'h012, 32'h0, 1'b0);
      chk("rd_deadbeef", 64'(bus_a.Mdatain), 64'hDEADBEEF);
      for (int s = 1; s < 3; s++) begin
         xact(s, 1'b1, 1'b0, 32'h0A5, 32'h1234_5678 + 32'(s), 1'b0);
         xact(s, 1'b0, 1'b1, 32'h0A5, 32'h0, 1'b0);
      end

      // Simultaneous Read/Write: write wins, Mdatain keeps the last read value.
      xact(0, 1'b1, 1'b1, 32'h7, 32'h0000_00AA, 1'b0);
      xact(0, 1'b0, 1'b1, 32'h7, 32'h0, 1'b0);
      chk("rw_prio", 64'(bus_a.Mdatain), 64'hAA);

      // Read pulsed during WAIT is dropped.
      xact(0, 1'b1, 1'b0, 32'h033, 32'hCAFE_0001, 1'b1);

      // Address wrap / range check.
      xact(0, 1'b1, 1'b0, 32'h0, 32'h0000_1234, 1'b0);
      xact(0, 1'b1, 1'b0, 32'h200, 32'h0000_0055, 1'b0);
      xact(0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);

      // Held Read: pulses separated by WS+2 low cycles, each returning RAM[3].
      xact(0, 1'b1, 1'b0, 32'h3, 32'h3333_0003, 1'b0);
      mdat_m[0] = mem_m[0][3];
      @(negedge clock);
      set_req(0, 1'b1, 1'b0, 32'h3, 32'h0);
      seen = 0;
      low  = 0;
      for (int k = 0; k < 60; k++) begin
         @(posedge clock); #1;
         if (bus_a.done) begin
            seen++;
            chk("hold_mdat", 64'(bus_a.Mdatain), 64'(mdat_m[0]));
            if (seen > 1) chk("hold_gap", 64'(low), 64'(WS_A + 2));
            low = 0;
            if (seen == 4) break;
         end else if (seen > 0) begin
            low++;
         end
      end
      set_req(0, 1'b0, 1'b0, '0, '0);
      chk("hold_pulses", 64'(seen), 64'd4);
      @(posedge clock); #1;

      // Clear held across the access edge of a pending write to addr 5.
      v5 = 32'h0505_5050;
      xact(0, 1'b1, 1'b0, 32'h5, v5, 1'b0);
      @(negedge clock);
      set_req(0, 1'b0, 1'b1, 32'h5, 32'hFFFF_0000);
      @(posedge clock); #1;
      set_req(0, 1'b0, 1'b0, '0, '0);
      repeat (WS_A) @(posedge clock);
      #1;
      clear = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      clear = 1'b0;
      for (int s = 0; s < 3; s++) mdat_m[s] = '0;
      chk("abort_busy", 64'(bus_a.busy), 64'd0);
      chk("abort_done", 64'(bus_a.done), 64'd0);
      chk("abort_mdat", 64'(bus_a.Mdatain), 64'd0);
      xact(0, 1'b0, 1'b1, 32'h5, 32'h0, 1'b0);
      chk("abort_nowrite", 64'(bus_a.Mdatain), 64'(v5));

      // Random traffic against the model.
      for (int i = 0; i < 60; i++) begin
         addr = {23'd0, 9'($urandom)};
         if ($urandom_range(0, 7) == 0) addr[31:AW] = 23'($urandom_range(1, 1000));
         wr = 1'($urandom);
         rd = 1'($urandom);
         if (!wr && !known[0][addr[AW-1:0]]) wr = 1'b1;
         if (!wr && !rd) rd = 1'b1;
         xact(0, wr, rd, addr, $urandom, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
